salt_mean_replacer: RTL and testbench

- Downstream stage of the non-salt neighbour counter.
- Takes one 3x3 window per transaction (P1..P9, centre P5) plus the counter's N_slt result.
- Clean centre pixel: passes it through. Noisy centre: replaces it with the truncated mean of the clean neighbours, computed by a sequential restoring divider.
- No clean neighbours: replaces it with the last emitted pixel (feedback).
- Sits between the window/counter stage and the output pixel stream.

---
 rtl/salt_mean_replacer_pkg.sv | 27 ++
 rtl/salt_mean_replacer_seq_divider.sv | 71 +++++++
 rtl/salt_or_not.sv | 11 +
 rtl/salt_mean_replacer.sv | 117 +++++++++++
 tb/tb_salt_mean_replacer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/salt_mean_replacer_pkg.sv
// Shared constants, FSM state type and helpers for the salt-and-pepper mean replacer.
package salt_mean_replacer_pkg;

    localparam int PW = 8;    // pixel width
    localparam int SW = 11;   // neighbour-sum width (8 x 254 = 2032 fits)

    // Noise pixel values: pepper is black, salt is white.
    localparam logic [7:0] PEPPER = 8'h00;
    localparam logic [7:0] SALT   = 8'hFF;

    // One quotient bit is produced per iteration, so the division takes SW iterations.
    localparam int DIV_ITERS = SW;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    // Clamp a neighbour-sum-wide quotient to the largest pixel value.
    function automatic logic [PW-1:0] saturate(input logic [SW-1:0] value);
        if (value > SW'(SALT))
            return SALT;
        return value[PW-1:0];
    endfunction

endpackage

// File: rtl/salt_mean_replacer_seq_divider.sv
// Sequential restoring divider: SW-bit dividend by a 4-bit divisor, one quotient bit per cycle.
// The first quotient bit is computed at the start edge, so done pulses SW-1 cycles after start.
module seq_divider #(
    parameter int SW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [3:0]    divisor,
    output logic [SW-1:0] quotient,
    output logic          done
);

    localparam int CW = $clog2(SW + 1);

    logic [3:0]    rem;       // partial remainder, always < divisor
    logic [3:0]    div_q;     // divisor captured at start
    logic [SW-1:0] quo;       // dividend bits still to consume, quotient bits shifted in from the right
    logic [CW-1:0] cnt;       // iterations remaining
    logic          done_q;

    logic [3:0]    rem_in;
    logic [3:0]    div_in;
    logic [SW-1:0] shift_src;
    logic [4:0]    partial;
    logic [4:0]    diff;
    logic          take;
    logic [3:0]    rem_next;

    // One restoring step: shift the next dividend bit into the remainder and subtract if it fits.
    always_comb begin
        rem_in    = start ? 4'd0     : rem;
        div_in    = start ? divisor  : div_q;
        shift_src = start ? dividend : quo;
        partial   = {rem_in, shift_src[SW-1]};
        diff      = partial - {1'b0, div_in};
        take      = (partial >= {1'b0, div_in});
        // When the subtraction is skipped, partial < divisor so it fits back into four bits.
        rem_next  = take ? diff[3:0] : partial[3:0];
    end

    // Divider state: load and do the first step on start, then iterate until the counter drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem    <= '0;
            div_q  <= '0;
            quo    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            rem    <= rem_next;
            div_q  <= divisor;
            quo    <= {shift_src[SW-2:0], take};
            cnt    <= CW'(SW - 1);
            done_q <= 1'b0;
        end else if (cnt != '0) begin
            rem    <= rem_next;
            quo    <= {shift_src[SW-2:0], take};
            cnt    <= cnt - 1'b1;
            done_q <= (cnt == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient = quo;
    assign done     = done_q;

endmodule

// File: rtl/salt_or_not.sv
// Per-pixel noise classifier: flags a pixel that is pure pepper (all zeros) or pure salt (all ones).
module salt_or_not #(
    parameter int PW = 8
) (
    input  logic [PW-1:0] pixel,
    output logic          noise
);

    assign noise = (pixel == {PW{1'b0}}) || (pixel == {PW{1'b1}});

endmodule

// File: rtl/salt_mean_replacer.sv
// Salt-and-pepper filter output stage: passes clean centre pixels, replaces noisy ones with the
// truncated mean of the clean neighbours, or with the last emitted pixel when none are clean.
module salt_mean_replacer #(
    parameter int PW = salt_mean_replacer_pkg::PW,
    parameter int SW = salt_mean_replacer_pkg::SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] P1,
    input  logic [PW-1:0] P2,
    input  logic [PW-1:0] P3,
    input  logic [PW-1:0] P4,
    input  logic [PW-1:0] P5,
    input  logic [PW-1:0] P6,
    input  logic [PW-1:0] P7,
    input  logic [PW-1:0] P8,
    input  logic [PW-1:0] P9,
    input  logic [3:0]    N_slt,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] P_out,
    output logic          out_valid,
    input  logic          out_ready
);

    import salt_mean_replacer_pkg::*;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] last_out;
    logic [PW-1:0] win [9];
    logic [8:0]    noise;
    logic [SW-1:0] sum;
    logic          div_start;
    logic          div_done;
    logic [SW-1:0] quotient;
    logic          accept;

    assign win = '{P1, P2, P3, P4, P5, P6, P7, P8, P9};

    for (genvar i = 0; i < 9; i++) begin : g_flag
        salt_or_not #(.PW(PW)) u_flag (
            .pixel (win[i]),
            .noise (noise[i])
        );
    end

    // Sum of clean neighbours; noisy neighbours and the centre contribute nothing.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4 && !noise[i])
                sum = sum + SW'(win[i]);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    seq_divider #(.SW(SW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum),
        .divisor  (N_slt),
        .quotient (quotient),
        .done     (div_done)
    );

    // Next-state and divider start decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_next = state;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!noise[4] || N_slt == 4'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                        div_start  = 1'b1;
                    end
                end
            end
            DIV:     if (div_done)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, output pixel and feedback register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            P_out    <= '0;
            last_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!noise[4])
                            P_out <= P5;
                        else if (N_slt == 4'd0)
                            P_out <= last_out;
                    end
                end
                DIV:     if (div_done)  P_out <= saturate(quotient);
                DONE:    if (out_ready) last_out <= P_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_salt_mean_replacer.sv
// Directed bench for salt_mean_replacer: table of windows with hand-computed outputs and
// latencies, plus hand-written backpressure and mid-division reset sequences.
module tb_salt_mean_replacer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] P1, P2, P3, P4, P5, P6, P7, P8, P9;
    logic [3:0] N_slt;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] P_out;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int n_vec  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    salt_mean_replacer dut (
        .clk       (clk),
        .rst       (rst),
        .P1        (P1),
        .P2        (P2),
        .P3        (P3),
        .P4        (P4),
        .P5        (P5),
        .P6        (P6),
        .P7        (P7),
        .P8        (P8),
        .P9        (P9),
        .N_slt     (N_slt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P_out     (P_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        string      name;
        logic [7:0] pix [9];
        logic [3:0] nslt;
        logic [7:0] exp_out;
        int         exp_lat;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input string name,
                                input int p1, input int p2, input int p3,
                                input int p4, input int p5, input int p6,
                                input int p7, input int p8, input int p9,
                                input int nslt, input int exp_out, input int exp_lat);
        vec_t v;
        v.name    = name;
        v.pix[0]  = 8'(p1); v.pix[1] = 8'(p2); v.pix[2] = 8'(p3);
        v.pix[3]  = 8'(p4); v.pix[4] = 8'(p5); v.pix[5] = 8'(p6);
        v.pix[6]  = 8'(p7); v.pix[7] = 8'(p8); v.pix[8] = 8'(p9);
        v.nslt    = 4'(nslt);
        v.exp_out = 8'(exp_out);
        v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_window(input vec_t v);
        P1 = v.pix[0]; P2 = v.pix[1]; P3 = v.pix[2];
        P4 = v.pix[3]; P5 = v.pix[4]; P6 = v.pix[5];
        P7 = v.pix[6]; P8 = v.pix[7]; P9 = v.pix[8];
        N_slt = v.nslt;
    endtask

    // Accept one window, measure cycles until out_valid, check the pixel, then handshake.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        drive_window(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, " P_out"}, 32'(P_out), 32'(v.exp_out));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        check({v.name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t div_win;
        vec_t clean_win;
        vec_t all_noise;
        int   lat;

        vecs[0] = mk("noise after reset", 0,255,0, 255,0,255, 0,0,255, 0,   0,  1);
        vecs[1] = mk("clean centre",      3,9,250, 17,100,0, 255,44,12, 8, 100,  1);
        vecs[2] = mk("full division",     10,20,30, 40,255,50, 60,70,80, 8, 45, 12);
        vecs[3] = mk("feedback 45",       255,0,255, 0,255,0, 255,0,255, 0, 45,  1);
        vecs[4] = mk("truncation 15/2",   0,255,7, 0,0,255, 8,255,0, 2,    7, 12);
        vecs[5] = mk("feedback 7",        0,0,0, 0,0,0, 0,0,0, 0,          7,  1);
        vecs[6] = mk("saturate 1600/1",   200,200,200, 200,255,200, 200,200,200, 1, 255, 12);
        vecs[7] = mk("clean centre 1",    0,0,0, 0,1,0, 0,0,0, 0,          1,  1);
        vecs[8] = mk("clean centre 254",  255,255,255, 255,254,255, 255,255,255, 0, 254, 1);
        vecs[9] = mk("max sum 2032/8",    254,254,254, 254,0,254, 254,254,254, 8, 254, 12);

        div_win   = vecs[2];
        clean_win = mk("held clean", 1,2,3, 4,77,6, 7,8,9, 8, 77, 1);
        all_noise = mk("noise after mid-div reset", 0,0,0, 0,255,0, 0,0,0, 0, 0, 1);
        drive_window(vecs[0]);

        // Reset state.
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset P_out",     32'(P_out),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result 45 held while a new window waits on in_valid.
        @(negedge clk);
        drive_window(div_win);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_window(clean_win);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("backpressure latency", 32'(lat), 32'd12);
        for (int c = 0; c < 5; c++) begin
            check("backpressure P_out stable",     32'(P_out),     32'd45);
            check("backpressure out_valid stable", 32'(out_valid), 32'd1);
            check("backpressure in_ready low",     32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("backpressure in_ready after handshake", 32'(in_ready),  32'd1);
        check("held window not yet accepted",          32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("held window out_valid", 32'(out_valid), 32'd1);
        check("held window P_out",     32'(P_out),     32'd77);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset five cycles into a division.
        drive_window(div_win);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-div reset out_valid", 32'(out_valid), 32'd0);
        check("mid-div reset in_ready",  32'(in_ready),  32'd1);
        check("mid-div reset P_out",     32'(P_out),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(all_noise);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
        $finish;
    end

endmodule
